// File: rtl/io_pkg.sv
// Shared IO address map: region codes, keyboard register layout, decode helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a; used by both the read controller and the write-side decoder.
package io_pkg;

    // addr[31:20] region codes
    localparam logic [11:0] REGION_DMEM = 12'h001;
    localparam logic [11:0] REGION_VGA  = 12'h002;
    localparam logic [11:0] REGION_KBD  = 12'h003;

    // Inside the keyboard region, addr[2] picks data (0) or status (1)
    localparam int KBD_REG_SEL_BIT = 2;

    // Keyboard status word layout: {23'b0, overflow, 3'b0, count[4:0]}
    localparam int KBD_STAT_CNT_LSB = 0;
    localparam int KBD_STAT_CNT_W   = 5;
    localparam int KBD_STAT_OVF_BIT = 8;

    typedef enum logic [1:0] {
        REG_UNMAPPED = 2'd0,
        REG_DMEM     = 2'd1,
        REG_VGA      = 2'd2,
        REG_KBD      = 2'd3
    } region_e;

    // Where the response register takes its data from in the response cycle
    typedef enum logic {
        RSEL_LOCAL = 1'b0,   // word captured in the request cycle
        RSEL_DMEM  = 1'b1    // data memory returns it one cycle later
    } rsel_e;

    // DMEM wins if a parameterised keyboard region ever collides with it
    function automatic region_e decode_region(input logic [11:0] code,
                                              input logic [11:0] kbd_code);
        region_e r;
        r = REG_UNMAPPED;
        if (code == REGION_DMEM) begin
            r = REG_DMEM;
        end else if (code == kbd_code) begin
            r = REG_KBD;
        end else if (code == REGION_VGA) begin
            r = REG_VGA;
        end
        return r;
    endfunction

    function automatic logic [31:0] kbd_status_word(input logic ovf,
                                                    input logic [KBD_STAT_CNT_W-1:0] cnt);
        logic [31:0] w;
        w = '0;
        w[KBD_STAT_CNT_LSB +: KBD_STAT_CNT_W] = cnt;
        w[KBD_STAT_OVF_BIT] = ovf;
        return w;
    endfunction

endpackage

// File: rtl/io_rd_ctrl_if.sv
// CPU read port, data-memory read side-channel and keyboard byte stream.
// Latency: n/a (signal bundle only).
// Backpressure: none; reads and keyboard strobes are accepted every cycle.
interface io_rd_ctrl_if;
    logic [31:0] addr;
    logic        rd_en;
    logic        dmem_rd_en;
    logic [31:0] dmem_rdata;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic [31:0] rdata;
    logic        rdata_valid;

    // Environment side: CPU, data memory and keyboard receiver
    modport master (
        output addr, rd_en, dmem_rdata, kbd_valid, kbd_data,
        input  dmem_rd_en, rdata, rdata_valid
    );

    // Read controller side
    modport slave (
        input  addr, rd_en, dmem_rdata, kbd_valid, kbd_data,
        output dmem_rd_en, rdata, rdata_valid
    );
endinterface

// File: rtl/kbd_fifo.sv
// Keyboard byte FIFO, DEPTH entries (power of two), show-ahead head on dout.
// Latency: push visible at dout the cycle after it is written into an empty FIFO.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop frees the slot this cycle, so a push into a full FIFO still lands
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage array, no reset needed: only read while count says it is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_rd_ctrl.sv
// Read-side IO controller: decodes CPU reads to DMEM, keyboard FIFO/status or unmapped.
// Latency: fixed 1 cycle, request in N -> rdata_valid pulse with data in N+1.
// Backpressure: none; one read per cycle back-to-back, excess keyboard bytes dropped.
module io_rd_ctrl
    import io_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] KBD_REGION = REGION_KBD
) (
    input  logic         clk,
    input  logic         rst_n,
    io_rd_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    region_e     region;
    logic        rd_acc;
    logic        kbd_data_rd;
    logic        kbd_stat_rd;

    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [CNT_W-1:0]          fifo_count;
    logic [KBD_STAT_CNT_W-1:0] stat_count;

    logic        ovf_q;
    logic        ovf_set;

    rsel_e       sel_d;
    rsel_e       sel_q;
    logic [31:0] local_d;
    logic [31:0] local_q;
    logic [31:0] hold_q;
    logic        valid_q;
    logic [31:0] rdata_mux;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[19:3], bus.addr[1:0]};

    assign region = decode_region(bus.addr[31:20], KBD_REGION);

    // A read in a reset cycle is dropped before it can touch any state
    assign rd_acc      = bus.rd_en && rst_n;
    assign kbd_data_rd = rd_acc && (region == REG_KBD) && !bus.addr[KBD_REG_SEL_BIT];
    assign kbd_stat_rd = rd_acc && (region == REG_KBD) &&  bus.addr[KBD_REG_SEL_BIT];

    assign bus.dmem_rd_en = rd_acc && (region == REG_DMEM);

    assign fifo_pop   = kbd_data_rd && !fifo_empty;
    assign stat_count = KBD_STAT_CNT_W'(fifo_count);

    // Byte lost only when full and no pop makes room in the same cycle
    assign ovf_set = bus.kbd_valid && fifo_full && !fifo_pop;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_kbd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.kbd_valid),
        .pop   (fifo_pop),
        .din   (bus.kbd_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Build the response word for keyboard/unmapped reads now; DMEM data comes next cycle
    always_comb begin
        sel_d   = RSEL_LOCAL;
        local_d = '0;
        if (region == REG_DMEM) begin
            sel_d = RSEL_DMEM;
        end else if (kbd_stat_rd) begin
            local_d = kbd_status_word(ovf_q, stat_count);
        end else if (kbd_data_rd && !fifo_empty) begin
            local_d = {24'b0, fifo_dout};
        end
    end

    // Sticky overflow: a same-cycle set beats the read-to-clear, the read sees the old value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (kbd_stat_rd) begin
            ovf_q <= 1'b0;
        end
    end

    // Response register: valid pulse, source select, captured word and held output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= RSEL_LOCAL;
            local_q <= '0;
            hold_q  <= '0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
                sel_q   <= sel_d;
                local_q <= local_d;
            end
            if (valid_q) begin
                hold_q <= rdata_mux;
            end
        end
    end

    assign rdata_mux       = (sel_q == RSEL_DMEM) ? bus.dmem_rdata : local_q;
    assign bus.rdata       = valid_q ? rdata_mux : hold_q;
    assign bus.rdata_valid = valid_q;

endmodule
